param_fifo: RTL and testbench
=============================

# param_fifo

Parametrised circular-buffer FIFO that replaces the fixed 64-bit shift-register FIFO behind the AFU's MMIO user register. Host writes to 0x0020 drive `push`, host reads of 0x0020 drive `pop`, and the AFU returns `q`. Unlike the shift-register version, it adds:
- full/empty/occupancy status;
- an almost-full threshold;
- sticky overflow/underflow error flags;
- optional first-word-fall-through output.

## Interface
Parameters:
- WIDTH, 64, data width in bits (≥1)
- DEPTH, 8, number of entries; power of two, ≥2
- AF_THRESH, DEPTH-2, `almost_full` asserts when count ≥ AF_THRESH (1..DEPTH)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- push  in  1  write request; `d` captured when accepted
- d  in  WIDTH  write data
- pop  in  1  read request
- q  out  WIDTH  read data
- q_valid  out  1  `q` holds valid popped/head data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- clr_err  in  1  clears sticky error flags
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

## Operation
Pointers:
- wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, and the MSB is the wrap bit.
- Address = low bits. Pointers wrap naturally modulo 2·DEPTH.
- full = low bits equal and MSBs differ.
- empty = pointers equal.

Push rules:
- Accepted iff !full, or full && pop (pop frees a slot the same cycle).
- An accepted push writes mem[wr_ptr] and increments wr_ptr.
- A rejected push sets `overflow`; memory and pointers are unchanged.

Pop rules:
- Accepted iff !empty.
- A pop while empty is rejected and sets `underflow`, even with a simultaneous push; the push is still accepted.

Count and flags:
- count += accepted push, −= accepted pop; push and pop in the same cycle leave count unchanged.
- clr_err clears both sticky flags. A new error in the same cycle wins: the flag stays set.

Reset values (rst_n low, asynchronous):
- Pointers and count: 0.
- Outputs: empty=1, full=0, almost_full=0, q=0, q_valid=0, overflow=0, underflow=0.
- Memory array is not reset.
- Reset mid-operation discards all contents immediately.

## Timing
Default (registered output):
- Accepted pop in cycle N → q = mem[rd_ptr] and q_valid=1 in cycle N+1.
- q_valid is a single-cycle pulse per accepted pop; q holds its value until the next accepted pop.

Status outputs:
- full, empty, almost_full and count are registered.
- They reflect the effect of cycle N's push/pop in cycle N+1.

Pushes:
- A pushed word is poppable in the cycle after the push (empty deasserts in N+1).
- Write-to-read latency for the value itself is 2 cycles in default mode.

## Configuration
- `PARAM_FIFO_FWFT_EN` defined: first-word-fall-through mode.
  - q = mem[rd_ptr] combinationally and q_valid = !empty.
  - pop acknowledges the displayed word; the next head appears in the following cycle.
  - Status, error and acceptance rules are unchanged.
- Macro undefined: registered-output behaviour as in Timing.

## Structure
- Shared package `fifo_pkg` holds:
  - a ptr-width helper function ($clog2(DEPTH)+1);
  - the default WIDTH/DEPTH localparams used by the AFU.
- Sub-module `fifo_mem`: DEPTH×WIDTH storage with one synchronous write port and one read port.
  - Read port is registered in default mode and asynchronous under the FWFT macro.
  - Allows RAM inference.
- Top-level `param_fifo` contains pointers, count, flags and the q/q_valid register.

## Test plan
All scenarios use WIDTH=64, DEPTH=8, AF_THRESH=6.
- Reset, then 8 pushes of 0x11..0x88:
  - almost_full rises after push 6 (count=6);
  - full=1 and count=8 after push 8;
  - then 8 pops → q = 0x11..0x88 in order, each one cycle after its pop, empty=1 at end.
- Full FIFO, push 0x99:
  - overflow=1, count stays 8;
  - draining yields 0x11..0x88, with no 0x99.
- Full FIFO, push 0xAA with pop in the same cycle:
  - count stays 8, no overflow, q=0x11;
  - after draining, the last word is 0xAA.
- Empty FIFO, pop and push 0x55 in the same cycle:
  - underflow=1, q_valid stays 0, count=1;
  - next pop → q=0x55.
  - Then clr_err together with a fresh empty pop → underflow remains 1.
  - clr_err alone → both flags 0.
- Wrap-around: push/pop 20 words 0x100..0x113 with occupancy kept at 3:
  - output order is preserved across two pointer wraps;
  - full never asserts.
- Reset mid-stream (count=5):
  - drop rst_n asynchronously → count=0, empty=1, q=0 immediately;
  - then, with PARAM_FIFO_FWFT_EN defined, push 0x77 → q=0x77 and q_valid=1 the next cycle, with no pop needed.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO package: the pointer-width helper and the AFU default geometry.
package fifo_pkg;

  // Default geometry of the AFU user-register FIFO.
  localparam int FIFO_WIDTH = 64;
  localparam int FIFO_DEPTH = 8;

  // Pointer width: address bits plus one wrap bit, so full and empty can be
  // told apart when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_fifo_if.sv
// FIFO bus bundle. The master is the host-side register logic, the slave is
// the FIFO itself.
//
// Handshake semantics: push and pop are single-cycle requests sampled on
// every rising clock edge. There is no back-pressure wait. A request that
// cannot be served is dropped, and the matching sticky error flag records
// it: overflow for a push to a full FIFO without a pop, underflow for a pop
// from an empty FIFO. Status outputs describe the state after the previous
// edge, so a requester checks full/empty before it asserts push/pop.
interface param_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
);

  localparam int CW = ptr_w(DEPTH);

  logic             push;
  logic [WIDTH-1:0] d;
  logic             pop;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, d, pop, clr_err,
    input  q, q_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  push, d, pop, clr_err,
    output q, q_valid, full, empty, almost_full, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH FIFO storage: one synchronous write port and one read port.
// With PARAM_FIFO_FWFT_EN defined, the read port is asynchronous, so the head
// word can be shown directly. Otherwise the read port is registered and loads
// only on re. Only the read register is reset; the array is never reset,
// which keeps it inferable as RAM.
module fifo_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: store the accepted push word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef PARAM_FIFO_FWFT_EN
  // Asynchronous read: the head word is visible without a pop.
  assign rdata = mem[raddr];

  logic unused_rd;
  assign unused_rd = &{1'b0, re, rst_n};
`else
  // Registered read: load the head word on an accepted pop. If the FIFO is
  // full and a push writes the same slot in that cycle, this captures the
  // old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/param_fifo.sv
// Parametrised circular-buffer FIFO behind the AFU MMIO user register.
// It keeps the pointers, occupancy count, registered status flags, sticky
// error flags and the q/q_valid output stage. Storage is in fifo_mem.
// Build option: PARAM_FIFO_FWFT_EN selects first-word-fall-through output.
// Without it, q is registered and follows each accepted pop by one cycle.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2
) (
  input  logic        clk,
  input  logic        rst_n,
  param_fifo_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_nxt, rd_nxt;
  logic [PW-1:0]    count_q, count_nxt;
  logic             full_q, empty_q, af_q;
  logic             ovf_q, unf_q;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] mem_rdata;

  // Acceptance and next-state arithmetic. A full FIFO still takes a push
  // when a pop frees a slot in the same cycle. A pop needs a stored word.
  always_comb begin
    push_ok   = bus.push && (!full_q || bus.pop);
    pop_ok    = bus.pop && !empty_q;
    wr_nxt    = wr_ptr + PW'(push_ok);
    rd_nxt    = rd_ptr + PW'(pop_ok);
    count_nxt = count_q + PW'(push_ok) - PW'(pop_ok);
  end

  // Pointers and registered status. full and empty come from the next
  // pointers: equal address bits with different wrap bits means full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      count_q <= count_nxt;
      full_q  <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
      empty_q <= (wr_nxt == rd_nxt);
      af_q    <= (int'(count_nxt) >= AF_THRESH);
    end
  end

  // Sticky error flags. A new error in the same cycle wins over clr_err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (bus.push && !push_ok) ovf_q <= 1'b1;
      else if (bus.clr_err)     ovf_q <= 1'b0;
      if (bus.pop && !pop_ok)   unf_q <= 1'b1;
      else if (bus.clr_err)     unf_q <= 1'b0;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.d),
    .re    (pop_ok),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (mem_rdata)
  );

`ifdef PARAM_FIFO_FWFT_EN
  // Show the head word whenever one is stored; force zero while empty so
  // the stale array contents never reach q.
  assign bus.q       = empty_q ? '0 : mem_rdata;
  assign bus.q_valid = !empty_q;
`else
  logic q_valid_q;

  // q_valid pulses for one cycle after each accepted pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_valid_q <= 1'b0;
    else        q_valid_q <= pop_ok;
  end

  assign bus.q       = mem_rdata;
  assign bus.q_valid = q_valid_q;
`endif

  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.almost_full = af_q;
  assign bus.count       = count_q;
  assign bus.overflow    = ovf_q;
  assign bus.underflow   = unf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo with WIDTH=64, DEPTH=8, AF_THRESH=6.
// Sections: reset values, a table of directed vectors, wrap-around order,
// asynchronous reset mid-stream, then randomized traffic. Every step is
// compared against a queue-based reference model.
module tb_param_fifo;

  localparam int W  = 64;
  localparam int D  = 8;
  localparam int AF = 6;

  logic clk;
  logic rst_n;

  param_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  param_fifo #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];   // words currently stored, head first
  logic         m_ovf, m_unf;
  logic [W-1:0] m_q;
  logic         m_qv;

  logic [W-1:0] got_q[$];   // words seen leaving the FIFO
  bit           saw_full;

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_q   = '0;
    m_qv  = 1'b0;
  endtask

  task automatic model_apply(input logic p, input logic [W-1:0] dv, input logic pp, input logic c);
    bit is_full, is_empty, push_ok, pop_ok;
    logic [W-1:0] w;
    is_full  = (exp_q.size() == D);
    is_empty = (exp_q.size() == 0);
    pop_ok   = pp && !is_empty;
    push_ok  = p && (!is_full || pp);
    m_qv = 1'b0;
    if (pop_ok) begin
      w    = exp_q.pop_front();
      m_q  = w;
      m_qv = 1'b1;
    end
    if (push_ok) exp_q.push_back(dv);
    if (p && !push_ok) m_ovf = 1'b1;
    else if (c)        m_ovf = 1'b0;
    if (pp && is_empty) m_unf = 1'b1;
    else if (c)         m_unf = 1'b0;
`ifdef PARAM_FIFO_FWFT_EN
    m_q  = (exp_q.size() != 0) ? exp_q[0] : '0;
    m_qv = (exp_q.size() != 0);
`endif
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".count"}, W'(bus.count), W'(exp_q.size()));
    chk({tag, ".full"},  W'(bus.full),  W'(exp_q.size() == D));
    chk({tag, ".empty"}, W'(bus.empty), W'(exp_q.size() == 0));
    chk({tag, ".af"},    W'(bus.almost_full), W'(exp_q.size() >= AF));
    chk({tag, ".ovf"},   W'(bus.overflow),  W'(m_ovf));
    chk({tag, ".unf"},   W'(bus.underflow), W'(m_unf));
    chk({tag, ".q"},     bus.q, m_q);
    chk({tag, ".qv"},    W'(bus.q_valid), W'(m_qv));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive on the falling edge, sample 1 ns after the rise.
  task automatic step(input logic p, input logic [W-1:0] dv, input logic pp,
                      input logic c, input string tag);
    @(negedge clk);
    bus.push    = p;
    bus.d       = dv;
    bus.pop     = pp;
    bus.clr_err = c;
    model_apply(p, dv, pp, c);
`ifdef PARAM_FIFO_FWFT_EN
    if (pp && bus.q_valid) got_q.push_back(bus.q);
`endif
    @(posedge clk);
    #1;
`ifndef PARAM_FIFO_FWFT_EN
    if (bus.q_valid) got_q.push_back(bus.q);
`endif
    if (bus.full) saw_full = 1'b1;
    model_check(tag);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         push;
    logic         pop;
    logic         clr;
    logic [W-1:0] d;
    logic [3:0]   cnt;
    logic         full;
    logic         empty;
    logic         af;
    logic         ovf;
    logic         unf;
    logic [W-1:0] q;     // registered-output expectation
    logic         qv;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic push, logic pop, logic clr, logic [W-1:0] d,
                                  int cnt, logic full, logic empty, logic af,
                                  logic ovf, logic unf, logic [W-1:0] q, logic qv);
    vec_t v;
    v.push = push; v.pop = pop; v.clr = clr; v.d = d;
    v.cnt = 4'(cnt); v.full = full; v.empty = empty; v.af = af;
    v.ovf = ovf; v.unf = unf; v.q = q; v.qv = qv;
    vecs.push_back(v);
  endfunction

  task automatic build_table();
    // Fill with 0x11..0x88.
    for (int i = 1; i <= 8; i++)
      add_vec(1, 0, 0, 64'h11 * 64'(i), i, i == 8, 0, i >= AF, 0, 0, 64'h0, 0);
    // Push while full: rejected.
    add_vec(1, 0, 0, 64'h99, 8, 1, 0, 1, 1, 0, 64'h0, 0);
    // Drain: 0x11..0x88 in order, no 0x99.
    for (int j = 1; j <= 8; j++)
      add_vec(0, 1, 0, 64'h0, 8 - j, 0, j == 8, (8 - j) >= AF, 1, 0, 64'h11 * 64'(j), 1);
    // clr_err alone clears overflow; q holds.
    add_vec(0, 0, 1, 64'h0, 0, 0, 1, 0, 0, 0, 64'h88, 0);
    // Refill.
    for (int i = 1; i <= 8; i++)
      add_vec(1, 0, 0, 64'h11 * 64'(i), i, i == 8, 0, i >= AF, 0, 0, 64'h88, 0);
    // Full: push 0xAA with pop in the same cycle.
    add_vec(1, 1, 0, 64'hAA, 8, 1, 0, 1, 0, 0, 64'h11, 1);
    // Drain: 0x22..0x88 then 0xAA.
    for (int j = 2; j <= 8; j++)
      add_vec(0, 1, 0, 64'h0, 9 - j, 0, 0, (9 - j) >= AF, 0, 0, 64'h11 * 64'(j), 1);
    add_vec(0, 1, 0, 64'h0, 0, 0, 1, 0, 0, 0, 64'hAA, 1);
    // Empty: pop + push 0x55, pop rejected, push accepted.
    add_vec(1, 1, 0, 64'h55, 1, 0, 0, 0, 0, 1, 64'hAA, 0);
    add_vec(0, 1, 0, 64'h0, 0, 0, 1, 0, 0, 1, 64'h55, 1);
    // clr_err with a fresh empty pop: underflow stays set.
    add_vec(0, 1, 1, 64'h0, 0, 0, 1, 0, 0, 1, 64'h55, 0);
    // clr_err alone: both flags clear.
    add_vec(0, 0, 1, 64'h0, 0, 0, 1, 0, 0, 0, 64'h55, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string tag;
    int    pw, ppw;
    rst_n       = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    bus.d       = '0;
    saw_full    = 1'b0;
    model_reset();
    build_table();

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", W'(bus.count), 0);
    chk("rst.empty", W'(bus.empty), 1);
    chk("rst.full",  W'(bus.full), 0);
    chk("rst.af",    W'(bus.almost_full), 0);
    chk("rst.q",     bus.q, 0);
    chk("rst.qv",    W'(bus.q_valid), 0);
    chk("rst.ovf",   W'(bus.overflow), 0);
    chk("rst.unf",   W'(bus.underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int k = 0; k < vecs.size(); k++) begin
      tag = $sformatf("tbl%0d", k);
      step(vecs[k].push, vecs[k].d, vecs[k].pop, vecs[k].clr, tag);
      chk({tag, ".t_count"}, W'(bus.count), W'(vecs[k].cnt));
      chk({tag, ".t_full"},  W'(bus.full),  W'(vecs[k].full));
      chk({tag, ".t_empty"}, W'(bus.empty), W'(vecs[k].empty));
      chk({tag, ".t_af"},    W'(bus.almost_full), W'(vecs[k].af));
      chk({tag, ".t_ovf"},   W'(bus.overflow),  W'(vecs[k].ovf));
      chk({tag, ".t_unf"},   W'(bus.underflow), W'(vecs[k].unf));
`ifndef PARAM_FIFO_FWFT_EN
      chk({tag, ".t_q"},     bus.q, vecs[k].q);
      chk({tag, ".t_qv"},    W'(bus.q_valid), W'(vecs[k].qv));
`endif
    end

    // Wrap-around: 20 words at occupancy 3.
    got_q.delete();
    saw_full = 1'b0;
    for (int k = 0; k < 3; k++)  step(1, 64'h100 + 64'(k), 0, 0, "wrap_fill");
    for (int k = 3; k < 20; k++) step(1, 64'h100 + 64'(k), 1, 0, "wrap_run");
    for (int k = 0; k < 3; k++)  step(0, 64'h0, 1, 0, "wrap_drain");
    chk("wrap.n_out", W'(got_q.size()), 20);
    for (int k = 0; k < 20; k++)
      chk($sformatf("wrap.out%0d", k), (k < got_q.size()) ? got_q[k] : 'x, 64'h100 + 64'(k));
    chk("wrap.never_full", W'(saw_full), 0);

    // Asynchronous reset mid-stream at count=5.
    for (int k = 0; k < 5; k++) step(1, 64'h200 + 64'(k), 0, 0, "mid_fill");
    chk("mid.count5", W'(bus.count), 5);
    #3;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.clr_err = 1'b0;
    rst_n       = 1'b0;
    #1;
    model_reset();
    chk("mid.count", W'(bus.count), 0);
    chk("mid.empty", W'(bus.empty), 1);
    chk("mid.full",  W'(bus.full), 0);
    chk("mid.q",     bus.q, 0);
    chk("mid.qv",    W'(bus.q_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 64'h77, 0, 0, "post_rst_push");
`ifdef PARAM_FIFO_FWFT_EN
    chk("fwft.q",  bus.q, 64'h77);
    chk("fwft.qv", W'(bus.q_valid), 1);
`else
    chk("reg.q_no_pop",  bus.q, 64'h0);
    chk("reg.qv_no_pop", W'(bus.q_valid), 0);
`endif

    // Randomized traffic in three phases: fill-heavy, drain-heavy, balanced.
    for (int cyc = 0; cyc < 450; cyc++) begin
      case (cyc / 150)
        0:       begin pw = 75; ppw = 30; end
        1:       begin pw = 25; ppw = 75; end
        default: begin pw = 50; ppw = 50; end
      endcase
      step($urandom_range(0, 99) < pw, {$urandom, $urandom},
           $urandom_range(0, 99) < ppw, $urandom_range(0, 19) == 0,
           $sformatf("rnd%0d", cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
